// File: rtl/i2s_receiver.sv
// i2s_receiver: Philips-format I2S slave receiver, oversampled and deserialised in the clk domain.
// Define I2S_RX_FS_MEAS_EN to add the fs_period frame-length measurement output.
module i2s_receiver #(
   parameter int I2S_BITS = 24,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i2s_bck,
   input  logic                i2s_lrck,
   input  logic                i2s_data,
   output logic [I2S_BITS-1:0] left,
   output logic [I2S_BITS-1:0] right,
   output logic                valid,
   output logic                locked,
`ifdef I2S_RX_FS_MEAS_EN
   output logic [15:0]         fs_period,
`endif
   output logic                frame_err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [5:0] NB = 6'(I2S_BITS);
   typedef enum logic {HUNT, RECV} state_t;
   state_t state, state_nx;
   logic [2:0] bck_s;
   logic [1:0] lrck_s, data_s;
   logic lrck_q;
   logic [5:0] cnt, cnt_nx;
   logic [I2S_BITS-1:0] sh, word_nx, hold;
   logic [TW-1:0] tcnt;
   logic rise, fall_ev, raise_ev, short_slot, timeout, left_end, right_end, err;
   assign rise       = bck_s[1] & ~bck_s[2];
   assign fall_ev    = rise & lrck_q & ~lrck_s[1];
   assign raise_ev   = rise & ~lrck_q & lrck_s[1];
   assign cnt_nx     = (cnt == 6'd63) ? cnt : cnt + 6'd1;
   assign word_nx    = (cnt < NB) ? {sh[I2S_BITS-2:0], data_s[1]} : sh;
   assign short_slot = cnt_nx < NB;
   assign timeout    = !rise && tcnt == TW'(TIMEOUT - 1);
   always_comb begin
      state_nx  = state;
      left_end  = 1'b0;
      right_end = 1'b0;
      err       = 1'b0;
      if (timeout)
         state_nx = HUNT;
      else if (state == HUNT)
         state_nx = fall_ev ? RECV : HUNT;
      else if (fall_ev | raise_ev) begin
         err       = short_slot;
         left_end  = raise_ev & ~short_slot;
         right_end = fall_ev & ~short_slot;
         // a short slot ended by an lrck fall is itself the new alignment edge
         state_nx  = (short_slot & raise_ev) ? HUNT : RECV;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= HUNT;
      else       state <= state_nx;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bck_s     <= '0;
         lrck_s    <= '0;
         data_s    <= '0;
         lrck_q    <= 1'b0;
         cnt       <= '0;
         sh        <= '0;
         hold      <= '0;
         tcnt      <= '0;
         left      <= '0;
         right     <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         bck_s     <= {bck_s[1:0], i2s_bck};
         lrck_s    <= {lrck_s[0], i2s_lrck};
         data_s    <= {data_s[0], i2s_data};
         valid     <= right_end;
         frame_err <= err;
         tcnt      <= rise ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
         if (rise) lrck_q <= lrck_s[1];
         if (timeout | (state == HUNT) | fall_ev | raise_ev) begin
            cnt <= '0;
            sh  <= '0;
         end else if (rise) begin
            cnt <= cnt_nx;
            sh  <= word_nx;
         end
         if (timeout)       hold <= '0;
         else if (left_end) hold <= word_nx;
         if (right_end) begin
            right  <= word_nx;
            left   <= hold;
            locked <= 1'b1;
         end else if (err | timeout)
            locked <= 1'b0;
      end
`ifdef I2S_RX_FS_MEAS_EN
   logic [15:0] fcnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fcnt      <= '0;
         fs_period <= '0;
      end else begin
         fcnt      <= fall_ev ? 16'd1 : (&fcnt) ? fcnt : fcnt + 16'd1;
         fs_period <= (err | timeout) ? 16'd0 : right_end ? fcnt : fs_period;
      end
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: frame-table stimulus with a scoreboard of expected left/right pairs.
`timescale 1ns/1ps
module tb_i2s_receiver;
   localparam real TCLK = 41.6667;
   localparam real H441 = 177.154;
   localparam real H48 = 162.760;
   localparam real H48_48 = 217.014;
   logic clk = 0, reset = 1, bck = 0, lrck = 0, data = 0;
   logic [23:0] left, right;
   logic valid, locked, frame_err;
`ifdef I2S_RX_FS_MEAS_EN
   logic [15:0] fs_period;
`endif
   i2s_receiver dut (
      .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_lrck(lrck), .i2s_data(data),
      .left(left), .right(right), .valid(valid), .locked(locked),
`ifdef I2S_RX_FS_MEAS_EN
      .fs_period(fs_period),
`endif
      .frame_err(frame_err));
   always #(TCLK / 2) clk = ~clk;
   typedef struct { logic [23:0] l; logic [23:0] r; int w; bit ev; } vec_t;
   typedef struct { logic [23:0] l; logic [23:0] r; real t; int fs; } exp_t;
   vec_t tab [19];
   exp_t sb [$];
   int n_chk = 0, n_pass = 0, n_valid = 0, n_err = 0, fs_exp = 0;
   logic pend = 0;
   bit pend_exp = 0;
   logic [23:0] pend_l, pend_r;
   real t_last = 0;
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask
   task automatic check_range(input string nm, input int got, input int lo, input int hi);
      n_chk++;
      if (got >= lo && got <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
   endtask
   task automatic send_bit(input logic lr, input logic d, input real half);
      bck = 0; lrck = lr; data = d;
      #(half);
      bck = 1; t_last = $realtime;
      #(half);
   endtask
   // the first period of each slot carries the last bit of the previous slot
   task automatic send_slot(input logic lr, input logic [23:0] word, input int w, input real half);
      for (int k = 0; k < w; k++) begin
         if (k == 0 && !lr && pend_exp) begin
            sb.push_back('{pend_l, pend_r, $realtime + half, fs_exp});
            pend_exp = 0;
         end
         send_bit(lr, pend, half);
         pend = (k < 24) ? word[23-k] : 1'b0;
      end
   endtask
   task automatic run_frames(input int first, input int last, input real half, input int fs);
      fs_exp = fs; pend = 0; pend_exp = 0;
      for (int i = first; i <= last; i++) begin
         send_slot(0, tab[i].l, tab[i].w, half);
         send_slot(1, tab[i].r, tab[i].w, half);
         pend_exp = tab[i].ev; pend_l = tab[i].l; pend_r = tab[i].r;
      end
   endtask
   task automatic close_and_idle(input real half);
      if (pend_exp) sb.push_back('{pend_l, pend_r, $realtime + half, fs_exp});
      pend_exp = 0;
      send_bit(0, pend, half);
      bck = 0;
      repeat (100) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      check("idle_unlocked", {31'd0, locked}, 0);
`ifdef I2S_RX_FS_MEAS_EN
      check("fs_hunt_zero", {16'd0, fs_period}, 0);
`endif
   endtask
   always @(negedge clk) if (!reset) begin
      if (frame_err) begin
         n_err++;
         check("err_unlock", {31'd0, locked}, 0);
      end
      if (valid) begin
         n_valid++;
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_valid: got left %h right %h expected no valid", left, right);
         end else begin
            automatic exp_t e = sb.pop_front();
            check("left", {8'd0, left}, {8'd0, e.l});
            check("right", {8'd0, right}, {8'd0, e.r});
            check("locked_on_valid", {31'd0, locked}, 1);
            check_range("latency_halfclk", int'(2.0 * ($realtime - e.t) / TCLK), 1, 9);
`ifdef I2S_RX_FS_MEAS_EN
            if (e.fs != 0) check_range("fs_period", int'(fs_period), e.fs - 1, e.fs + 1);
`endif
         end
      end
   end
   initial begin
      int v0, e0, c;
      tab[0]  = '{24'hA5A5A5, 24'h5A5A5A, 32, 1'b0};
      tab[1]  = '{24'hA5A5A5, 24'h5A5A5A, 32, 1'b1};
      tab[2]  = '{24'h000001, 24'hFFFFFF, 32, 1'b1};
      tab[3]  = '{24'h800001, 24'h7FFFFE, 24, 1'b0};
      for (int i = 4; i <= 11; i++) tab[i] = '{24'h800001, 24'h7FFFFE, 24, 1'b1};
      tab[12] = '{24'h111111, 24'h222222, 32, 1'b0};
      tab[13] = '{24'h333333, 24'h444444, 32, 1'b1};
      tab[14] = '{24'h555555, 24'h666666, 16, 1'b0};
      tab[15] = '{24'h777777, 24'h888888, 32, 1'b1};
      tab[16] = '{24'h999999, 24'hAAAAAA, 32, 1'b1};
      tab[17] = '{24'h0F0F0F, 24'hF0F0F0, 32, 1'b0};
      tab[18] = '{24'h123456, 24'h654321, 32, 1'b1};
      for (int i = 0; i < 8; i++) begin
         send_bit(logic'(i % 2), 1'b1, H441);
         check("rst_strobes", {29'd0, valid, locked, frame_err}, 0);
      end
      check("rst_left", {8'd0, left}, 0);
      check("rst_right", {8'd0, right}, 0);
      bck = 0; lrck = 0; data = 0;
      repeat (4) @(negedge clk);
      reset = 0;
      repeat (4) @(negedge clk);
      v0 = n_valid; e0 = n_err;
      run_frames(0, 2, H441, 0);
      close_and_idle(H441);
      check("a_valid_count", n_valid - v0, 2);
      v0 = n_valid; e0 = n_err;
      run_frames(3, 11, H48_48, 0);
      close_and_idle(H48_48);
      check("b_valid_count", n_valid - v0, 8);
      check("b_no_err", n_err - e0, 0);
      v0 = n_valid; e0 = n_err;
      run_frames(12, 16, H48, 0);
      close_and_idle(H48);
      check("c_err_once", n_err - e0, 1);
      check("c_valid_count", n_valid - v0, 3);
`ifdef I2S_RX_FS_MEAS_EN
      run_frames(0, 2, H441, 544);
      close_and_idle(H441);
      run_frames(0, 2, H48, 500);
      close_and_idle(H48);
`endif
      v0 = n_valid;
      run_frames(17, 18, H441, 0);
      send_slot(0, 24'hABCDEF, 32, H441);
      send_slot(1, 24'hFEDCBA, 16, H441);
      bck = 0;
      check("d_locked_before", {31'd0, locked}, 1);
      c = 0;
      while (locked && c < 100) begin
         @(negedge clk);
         c++;
      end
      check_range("d_timeout_clks", int'(($realtime - t_last) / TCLK), 64, 70);
      repeat (100 - c) @(negedge clk);
      check("d_left_kept", {8'd0, left}, 32'h123456);
      check("d_right_kept", {8'd0, right}, 32'h654321);
      check("d_valid_count", n_valid - v0, 1);
      check("d_sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- RTL I2S slave receiver for the MCU serial audio link (i2s_mcu_bck / i2s_mcu_lrck / i2s_mcu_data).
- Oversamples the three I2S lines in the clk domain (24 MHz) and deserialises Philips-format, MSB-first frames.
- Emits one left/right sample pair per frame with a single-cycle strobe, plus lock and frame-error status.
- Sits between the MCU I2S pins and the DSD/PCM processing path inside snos.

Parameters:
- I2S_BITS, 24: sample word width; must equal common::I2S_BITS.
- TIMEOUT, 64: clk cycles without a BCK rising edge before lock is dropped.

Ports:
- clk  input  1  logic clock, 24 MHz.
- reset  input  1  asynchronous, active-high reset.
- i2s_bck  input  1  I2S bit clock, asynchronous to clk, ≤ clk/4.
- i2s_lrck  input  1  word select: 0 = left, 1 = right.
- i2s_data  input  1  serial data, MSB first.
- left  output  I2S_BITS  last received left sample.
- right  output  I2S_BITS  last received right sample.
- valid  output  1  one-clk strobe: new left/right pair.
- locked  output  1  receiver is frame-aligned.
- frame_err  output  1  one-clk strobe: short slot detected.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all outputs 0; state HUNT; all counters and shift registers 0.
- Input synchronisation:
  - 2-FF synchroniser on bck, lrck and data, plus a third bck stage for edge detection.
  - A "rise" is one clk cycle in which the synced bck is 1 and the delayed bck is 0.
  - lrck and data are sampled on the same cycle as the rise.
- Slot definition: a slot is the set of rises after the rise on which an lrck change is sampled, up to and including the next such rise.
  - The rise that samples a new lrck value carries the last bit of the previous slot (I2S 1-bit delay).
- Bit counter:
  - 6 bits, saturating at 63, incremented on every rise in RECV.
  - While count < I2S_BITS, data is shifted into the shift register MSB-first; bits beyond I2S_BITS in a wider slot are ignored.
  - After the slot-end evaluation, counter and shift register are cleared.
- State machine:
  - HUNT: wait for a rise sampling an lrck 1->0 change, then go to RECV. No data is captured before that rise.
  - RECV, end of a left slot (lrck 0->1 sampled): the shifted word goes into the left holding register.
  - RECV, end of a right slot (lrck 1->0 sampled): right <= word, left <= holding register, valid pulses, locked <= 1.
- Latency: valid is asserted at most 4 clk cycles after the i2s_bck pin rising edge that ends the right slot. left and right are stable from the valid cycle until the next valid.
- Short slot (slot ended with count < I2S_BITS): frame_err pulses 1 cycle, no valid for that frame, locked <= 0, state -> HUNT. The lrck change that ended the short slot is evaluated as a HUNT alignment edge.
- Timeout: counts clk cycles since the last rise, saturating. On reaching TIMEOUT:
  - state -> HUNT, locked <= 0;
  - the partial word and the left holding register are discarded;
  - left and right keep their last values.
- Simultaneous events: a rise clears the timeout counter in the same cycle, so timeout and slot end can never coincide.
- Reset mid-frame: asynchronous clear; the first valid after reset requires a full left slot followed by a full right slot.

Optional Feature:
- Macro: I2S_RX_FS_MEAS_EN.
- Defined:
  - Adds output fs_period [15:0] = clk cycles between successive lrck 1->0 rises, 16-bit saturating.
  - Updated in the same cycle as valid; 0 while locked = 0.
  - Used by MCU-side logic to distinguish the 44.1 kHz and 48 kHz families (24 MHz clk: 544 vs 500).
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset with bck toggling -> left = right = 0, valid = locked = frame_err = 0 throughout.
- 64fs at 44.1 kHz, 32-bit slots, frames L = 24'hA5A5A5 / R = 24'h5A5A5A, then L = 24'h000001 / R = 24'hFFFFFF:
  - no valid for the partial first frame;
  - then one valid per frame with exact values and ≤ 4 clk latency;
  - locked = 1 from the first valid.
- 48fs, 24-bit slots, L = 24'h800001 / R = 24'h7FFFFE, 8 frames -> 8 valid pulses, values exact, frame_err never asserted.
- Locked stream followed by one frame with 16-bit slots:
  - frame_err pulses once, locked = 0, no valid for that frame;
  - next two full frames produce a valid with correct data.
- Locked stream, then bck held low for 100 clk mid-right-slot:
  - locked drops at TIMEOUT = 64 cycles after the last rise;
  - no valid for the partial frame; left/right keep their previous values.
- With I2S_RX_FS_MEAS_EN: 44.1 kHz -> fs_period = 544 ± 1; switch to 48 kHz -> after re-lock fs_period = 500 ± 1; during HUNT fs_period = 0.
